// File: rtl/dequant_unpack.sv
// Widening stage: subtracts a per-word zero point from each narrow lane, left-shifts
// into the wide accumulator format with saturation, and streams one lane per cycle.
module dequant_unpack #(
  parameter int IDW   = 8,
  parameter int ODW   = 16,
  parameter int LANES = 4,
  parameter int SW    = $clog2(ODW)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IDW-1:0]   in_data,
  input  logic                   in_last,
  input  logic [IDW-1:0]         zero_point,
  input  logic [SW-1:0]          shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ODW-1:0]         out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  // Wide enough to hold the largest shifted difference without overflow.
  localparam int PW = IDW + 1 + (1 << SW);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  function automatic logic signed [PW-1:0] widen(input logic signed [IDW-1:0] x,
                                                  input logic signed [IDW-1:0] zp,
                                                  input logic        [SW-1:0]  sh);
    logic signed [IDW:0]  d;
    logic signed [PW-1:0] dx;
    d  = {x[IDW-1], x} - {zp[IDW-1], zp};
    dx = {{(PW-IDW-1){d[IDW]}}, d};
    return dx <<< sh;
  endfunction

  function automatic logic signed [ODW-1:0] sat(input logic signed [PW-1:0] p);
    logic signed [ODW-1:0] r;
    if (p[PW-1:ODW-1] == {(PW-ODW+1){p[PW-1]}})
      r = p[ODW-1:0];
    else if (p[PW-1])
      r = {1'b1, {(ODW-1){1'b0}}};
    else
      r = {1'b0, {(ODW-1){1'b1}}};
    return r;
  endfunction

  logic [LANES*IDW-1:0]  data_p0;
  logic signed [IDW-1:0] zp_p0;
  logic [SW-1:0]         shift_p0;
  logic                  last_p0;
  logic [LW-1:0]         lane_p0;
  logic                  vld_p0;

  logic signed [ODW-1:0] data_p1;
  logic                  last_p1;
  logic                  vld_p1;

  logic                  advance;
  logic                  accept;
  logic                  at_last;
  logic signed [IDW-1:0] elem;
  logic signed [ODW-1:0] widened;

  assign at_last  = (lane_p0 == LAST_LANE);
  assign advance  = vld_p0 && (!vld_p1 || out_ready);
  assign in_ready = rst_n && (!vld_p0 || (at_last && advance));
  assign accept   = in_valid && in_ready;
  assign elem     = data_p0[lane_p0*IDW +: IDW];
  assign widened  = sat(widen(elem, zp_p0, shift_p0));

  // Stage p0: word buffer, payload captured on accept only
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0  <= in_data;
      zp_p0    <= zero_point;
      shift_p0 <= shift;
      last_p0  <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      lane_p0 <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      lane_p0 <= '0;
    end else if (advance) begin
      if (at_last) begin
        vld_p0  <= 1'b0;
        lane_p0 <= '0;
      end else begin
        lane_p0 <= lane_p0 + 1'b1;
      end
    end
  end

  // Stage p1: output register, held stable under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1  <= 1'b1;
      data_p1 <= widened;
      last_p1 <= last_p0 && at_last;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign busy      = vld_p0 || vld_p1;

endmodule

// File: tb/tb_dequant_unpack.sv
// Bench for dequant_unpack: vector table, directed multi-cycle sequences and
// randomized traffic checked by an arithmetic reference model and scoreboard.
module tb_dequant_unpack;
  localparam int IDW = 8, ODW = 16, LANES = 4, SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy;
  logic [LANES*IDW-1:0] in_data;
  logic [IDW-1:0] zero_point;
  logic [SW-1:0] shift;
  logic [ODW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [ODW-1:0] d; logic last;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [ODW-1:0] cap[$];
  logic prev_stall = 1'b0;
  logic [ODW-1:0] prev_data;
  logic prev_last;

  typedef struct {logic [IDW-1:0] elem; logic [IDW-1:0] zp; logic [SW-1:0] sh; logic [ODW-1:0] exp;} vec_t;
  vec_t tbl[13];

  dequant_unpack #(.IDW(IDW), .ODW(ODW), .LANES(LANES), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .zero_point(zero_point), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // Reference: exact integer arithmetic, then clamp to the signed output range.
  function automatic logic [ODW-1:0] model(input logic [IDW-1:0] x, input logic [IDW-1:0] zp,
                                           input logic [SW-1:0] sh);
    longint d, p;
    d = longint'($signed(x)) - longint'($signed(zp));
    p = d * (longint'(1) << sh);
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p[ODW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_output", out_data, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_last", out_last, e.last);
        end
      end
      if (in_valid && in_ready)
        for (int i = 0; i < LANES; i++)
          exp_q.push_back('{model(in_data[i*IDW +: IDW], zero_point, shift), in_last && (i == LANES-1)});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
      exp_q.delete();
    end
  end

  task automatic send(input logic [31:0] d, input logic [IDW-1:0] zp, input logic [SW-1:0] sh,
                      input logic last);
    in_valid = 1'b1; in_data = d; zero_point = zp; shift = sh; in_last = last;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic capture(input int n, input int budget);
    int cyc = 0;
    logic acc;
    cap.delete();
    while (cap.size() < n && cyc < budget) begin
      @(negedge clk);
      if (out_valid && out_ready) cap.push_back(out_data);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    chk("capture_count", cap.size(), n);
  endtask

  initial begin
    logic [ODW-1:0] bexp[4];
    logic [ODW-1:0] pexp[8];
    logic [31:0] w[3];
    int ptr;
    logic acc;

    tbl[0]  = '{8'h7F, 8'h80, 4'd8,  16'h7FFF};
    tbl[1]  = '{8'h80, 8'h7F, 4'd8,  16'h8000};
    tbl[2]  = '{8'h05, 8'h03, 4'd4,  16'h0020};
    tbl[3]  = '{8'h01, 8'h00, 4'd0,  16'h0001};
    tbl[4]  = '{8'hFF, 8'h00, 4'd15, 16'h8000};
    tbl[5]  = '{8'h7F, 8'hFF, 4'd7,  16'h4000};
    tbl[6]  = '{8'h40, 8'h00, 4'd9,  16'h7FFF};
    tbl[7]  = '{8'h80, 8'h00, 4'd8,  16'h8000};
    tbl[8]  = '{8'hC0, 8'h01, 4'd9,  16'h8000};
    tbl[9]  = '{8'h00, 8'h80, 4'd0,  16'h0080};
    tbl[10] = '{8'h80, 8'h7F, 4'd0,  16'hFF01};
    tbl[11] = '{8'h01, 8'h00, 4'd14, 16'h4000};
    tbl[12] = '{8'h01, 8'h00, 4'd15, 16'h7FFF};
    bexp = '{16'hFFFF, 16'h0001, 16'h007F, 16'hFF80};
    pexp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd8, 16'd16, 16'd24, 16'd32};
    w    = '{32'h01020304, 32'hF0E0D0C0, 32'h7F80FF00};

    in_valid = 0; in_data = '0; in_last = 0; zero_point = '0; shift = '0; out_ready = 1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // basic lane order and latency
    @(posedge clk); #1 send(32'h807F01FF, 8'h00, 4'd0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("basic_latency", out_valid, 0);
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      chk("basic_valid", out_valid, 1);
      chk("basic_data", out_data, bexp[i]);
      chk("basic_last", out_last, 0);
    end
    @(negedge clk);
    chk("basic_done_valid", out_valid, 0);
    chk("basic_done_busy", busy, 0);

    // vector table on lane 0
    for (int t = 0; t < 13; t++) begin
      @(posedge clk); #1 send({24'h0, tbl[t].elem}, tbl[t].zp, tbl[t].sh, 1'b0);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("tbl_valid", out_valid, 1);
      chk($sformatf("tbl_data[%0d]", t), out_data, tbl[t].exp);
      wait_idle();
    end

    // back-pressure with lane 1 held
    @(posedge clk); #1 send(32'h44332211, 8'h01, 4'd2, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 16'h0084);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("bp_lane1", out_data, 16'h0084);
    @(negedge clk); chk("bp_lane2", out_data, 16'h00C8);
    @(negedge clk); chk("bp_lane3", out_data, 16'h010C);
    @(negedge clk); chk("bp_done", out_valid, 0);
    wait_idle();

    // back-to-back words
    @(posedge clk); #1;
    ptr = 0;
    send(w[0], 8'h10, 4'd1, 1'b0);
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (c <= 12) chk($sformatf("b2b_in_ready[%0d]", c), in_ready, (c % 4) == 0);
      if (c >= 2 && c <= 13) begin
        chk("b2b_valid", out_valid, 1);
        chk($sformatf("b2b_last[%0d]", c), out_last, c == 13);
      end
      if (c == 14) chk("b2b_done", out_valid, 0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ptr++;
        if (ptr == 3) in_valid = 1'b0;
        else begin
          in_data = w[ptr];
          in_last = (ptr == 2);
        end
      end
    end
    in_last = 1'b0;
    wait_idle();

    // shift captured per word
    @(posedge clk); #1 send(32'h04030201, 8'h00, 4'd0, 1'b0);
    @(posedge clk); #1 shift = 4'd3;
    capture(8, 40);
    for (int i = 0; i < 8; i++)
      chk($sformatf("capture_param[%0d]", i), (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD, pexp[i]);
    wait_idle();

    // reset mid-word
    @(posedge clk); #1 send(32'h08070605, 8'h00, 4'd0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1 send(32'h0D0C0B0A, 8'h00, 4'd0, 1'b0);
    capture(4, 20);
    chk("post_rst_first", (cap.size() > 0) ? 32'(cap[0]) : 32'hDEAD, 16'h000A);
    chk("post_rst_last_lane", (cap.size() > 3) ? 32'(cap[3]) : 32'hDEAD, 16'h000D);
    wait_idle();

    // randomized traffic against the scoreboard
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_data    = $urandom;
      zero_point = IDW'($urandom);
      shift      = SW'($urandom_range(0, 15));
      in_last    = $urandom_range(0, 1);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dequant_unpack.md
# dequant_unpack

Streaming widening stage for the piped MAC datapath, the inverse of the rounding/narrowing stage. It accepts packed words of LANES narrow signed fixed-point elements and subtracts a per-word zero point from each element. It then left-shifts each result into the wide accumulator format, saturates it, and emits one wide element per cycle over a valid/ready stream. It sits between the quantized activation/weight memory read port and the MAC array input.

## Interface
- IDW, 8, narrow input element width (signed); must satisfy ODW >= IDW+1
- ODW, 16, wide output element width (signed)
- LANES, 4, elements per packed input word; must be >= 2
- SW, $clog2(ODW), width of the shift field
- clk  in  1  rising-edge clock; the block has one clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  LANES*IDW  packed elements; lane 0 = bits [IDW-1:0], emitted first
- in_last  in  1  word is the last of a tensor
- zero_point  in  IDW  signed zero point, captured with the word
- shift  in  SW  left-shift amount, captured with the word
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts the element
- out_data  out  ODW  widened signed element
- out_last  out  1  final lane of a word that carried in_last
- busy  out  1  word buffer or output register occupied

## Operation
- Two storage stages:
  - word buffer: data, zero_point, shift, last, lane_idx, buf_valid
  - output register: out_data, out_last, out_valid
- Accept: in_valid && in_ready at an edge loads the word buffer, sets buf_valid and clears lane_idx. zero_point and shift are sampled only at this edge; changes while draining affect the next word only.
- in_ready = rst_n && (!buf_valid || (lane_idx == LANES-1 && advance)), combinational.
- advance = buf_valid && (!out_valid || out_ready).
- On advance:
  - output register loads f(lane[lane_idx]).
  - out_last loads buf.last && lane_idx == LANES-1.
  - lane_idx increments. At LANES-1, buf_valid clears, unless a new word is accepted in the same edge, in which case the buffer reloads with lane_idx = 0.
- If out_valid && out_ready and there is no advance, out_valid clears.
- Arithmetic for f(x), all signed:
  - d = sext(x, IDW+1) - sext(zero_point, IDW+1)
  - p = d << shift, computed at IDW+1+2^SW bits
  - result = p saturated to [-2^(ODW-1), 2^(ODW-1)-1]
  - No rounding is required; the transform is exact up to saturation.
- busy = buf_valid || out_valid.

## Timing
- Reset, asynchronous on rst_n low:
  - buf_valid = 0, lane_idx = 0
  - out_valid = 0, out_data = 0, out_last = 0
  - busy = 0, in_ready = 0 while rst_n is low
  - in_ready = 1 from the first cycle after release.
- Latency: a word accepted at edge k produces lane 0 with out_valid high after edge k+1. Lane i appears after edge k+1+i when out_ready is held high.
- Throughput: 1 element/cycle. Back-to-back words need no bubble because a new word is accepted on the edge that consumes the last lane.
- Back-pressure: while out_valid && !out_ready, out_data and out_last are held stable, no advance occurs, and in_ready = 0 if buf_valid.
- A word arriving while the buffer is empty and out_valid && !out_ready is accepted and waits in the buffer.
- Reset mid-word discards all buffered lanes. No stale element is emitted after release.
- out_valid never drops without an out_ready handshake, except on reset.

## Test plan
Setup for all scenarios: IDW=8, ODW=16, LANES=4.

- **Basic order:** in_data = 0x807F01FF, zp = 0, shift = 0, out_ready = 1 -> out_data 0xFFFF, 0x0001, 0x007F, 0xFF80 on 4 consecutive cycles. First out_valid one cycle after the accept edge; out_last stays 0.
- **Zero point and saturation:**
  - elem 0x7F, zp = 0x80 (-128), shift = 8 -> 255<<8 = 65280 saturates to 0x7FFF.
  - elem 0x80, zp = 0x7F, shift = 8 -> 0x8000.
  - elem 0x05, zp = 0x03, shift = 4 -> 0x0020.
- **Back-pressure:** hold out_ready = 0 for 5 cycles with lane 1 valid -> out_data stable at the lane 1 value and in_ready = 0. After release, lanes 1..3 emerge in order with none lost or duplicated.
- **Back-to-back:** 3 words, in_last on word 3, in_valid and out_ready held 1 -> 12 outputs on 12 consecutive cycles. in_ready pulses high only on lane-3 edges; out_last is high only on output 12.
- **Parameter capture:** change shift from 0 to 3 while word A drains -> all of A unshifted, all of next word B shifted by 3.
- **Reset mid-word:** drive rst_n low after 2 lanes emitted -> out_valid, busy and in_ready drop to 0 immediately. After release, in_ready = 1 and the next output is lane 0 of a freshly sent word.
